cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single common data bus (CDB) among the functional units completing into the reorder buffer. Each cycle it grants at most one completion request, registers the winner's ROB tag and result onto the CDB, and thereby serialises all ROB completion writes and reservation-station wakeups. It sits between the functional-unit outputs and the ROB/RS/map-table CDB consumers.

---
 rtl/cdb_arbiter.sv | 118 +++++++++++
 tb/tb_cdb_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the single common data bus (CDB).
// Grants at most one functional-unit completion per cycle (combinational
// grant) and registers the winner's ROB tag and result as the broadcast.
// Optional feature macro: CDB_ARB_BRANCH_PRIO_EN -- FU 0 (branch unit) gets
// fixed highest priority and its grants leave the round-robin pointer alone.
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_FU-1:0]        fu_req,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_value,
    output logic [NUM_FU-1:0]        fu_grant,
    input  logic                     squash,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_value
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;

    logic              req_hit;
    logic [PTR_W-1:0]  win_idx;
    logic              grant_any;
    logic              ptr_upd;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_value;

    // Pick the requester nearest to rr_ptr going upward (with wrap).
    always_comb begin
        int best_d;
        int d;
        req_hit = 1'b0;
        win_idx = '0;
        ptr_upd = 1'b1;
        best_d  = NUM_FU;
        d       = 0;
        for (int j = 0; j < NUM_FU; j++) begin
            d = j - int'(rr_ptr_q);
            if (d < 0) d = d + NUM_FU;
            if (fu_req[j] && (d < best_d)) begin
                best_d  = d;
                req_hit = 1'b1;
                win_idx = PTR_W'(j);
            end
        end
`ifdef CDB_ARB_BRANCH_PRIO_EN
        // Branch unit overrides rotation and does not consume a turn.
        if (fu_req[0]) begin
            req_hit = 1'b1;
            win_idx = '0;
            ptr_upd = 1'b0;
        end
`endif
    end

    // Grants are suppressed during squash and while reset is held.
    assign grant_any = req_hit && !squash && reset;

    // One-hot grant plus mux of the winner's tag/value.
    always_comb begin
        fu_grant  = '0;
        sel_tag   = '0;
        sel_value = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            if (grant_any && (win_idx == PTR_W'(j))) begin
                fu_grant[j] = 1'b1;
                sel_tag     = fu_tag[j*TAG_W +: TAG_W];
                sel_value   = fu_value[j*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state: broadcast the winner, advance pointer past it.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        if (grant_any) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = sel_tag;
            cdb_value_d = sel_value;
            if (ptr_upd) begin
                if (win_idx == PTR_W'(NUM_FU - 1)) rr_ptr_d = '0;
                else                               rr_ptr_d = win_idx + 1'b1;
            end
        end
    end

    // Pointer and broadcast register, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_FU=4, TAG_W=3, DATA_W=32).
module tb_cdb_arbiter;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;

    logic                     clock;
    logic                     reset;
    logic [NUM_FU-1:0]        fu_req;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_value;
    logic [NUM_FU-1:0]        fu_grant;
    logic                     squash;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_value;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .fu_req(fu_req), .fu_tag(fu_tag),
        .fu_value(fu_value), .fu_grant(fu_grant), .squash(squash),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check broadcast register contents.
    task automatic chk_cdb(input string name, input logic v, input logic [TAG_W-1:0] t,
                           input logic [DATA_W-1:0] val);
        check({name, ".valid"}, 64'(cdb_valid), 64'(v));
        check({name, ".tag"},   64'(cdb_tag),   64'(t));
        check({name, ".value"}, 64'(cdb_value), 64'(val));
    endtask

    initial begin
        reset    = 1'b0;
        squash   = 1'b0;
        fu_req   = 4'b1111;
        fu_tag   = {3'd4, 3'd3, 3'd2, 3'd1};
        fu_value = {32'd104, 32'd103, 32'd102, 32'd101};

        // Reset held with all requesting
        #12;
        check("rst.grant", 64'(fu_grant), 64'h0);
        chk_cdb("rst", 1'b0, 3'd0, 32'd0);
        tick();
        check("rst.grant2", 64'(fu_grant), 64'h0);
        check("rst.valid2", 64'(cdb_valid), 64'h0);

        // Release: full contention rotates 0,1,2,3,0
        reset = 1'b1;
        #1;
        check("cont.g0", 64'(fu_grant), 64'b0001);
        tick(); #1;
        chk_cdb("cont.b0", 1'b1, 3'd1, 32'd101);
        check("cont.g1", 64'(fu_grant), 64'b0010);
        tick(); #1;
        chk_cdb("cont.b1", 1'b1, 3'd2, 32'd102);
        check("cont.g2", 64'(fu_grant), 64'b0100);
        tick(); #1;
        chk_cdb("cont.b2", 1'b1, 3'd3, 32'd103);
        check("cont.g3", 64'(fu_grant), 64'b1000);
        tick(); #1;
        chk_cdb("cont.b3", 1'b1, 3'd4, 32'd104);
        check("cont.g4", 64'(fu_grant), 64'b0001);
        tick();
        // rr_ptr=1 now; steer it to 3 via a grant to FU 2
        fu_req = 4'b0100;
        #1;
        chk_cdb("cont.b4", 1'b1, 3'd1, 32'd101);
        check("steer.g2", 64'(fu_grant), 64'b0100);
        tick();
        // rr_ptr=3: wrap to FU 0
        fu_req = 4'b0011;
        #1;
        check("wrap.g0", 64'(fu_grant), 64'b0001);
        tick(); #1;
        chk_cdb("wrap.b0", 1'b1, 3'd1, 32'd101);
        check("wrap.g1", 64'(fu_grant), 64'b0010);
        tick();
        // rr_ptr=2: squash scenario, FU 2 tag 5 value DEADBEEF
        fu_tag[2*TAG_W +: TAG_W]     = 3'd5;
        fu_value[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        fu_req = 4'b0100;
        #1;
        chk_cdb("wrap.b1", 1'b1, 3'd2, 32'd102);
        check("sq.gN", 64'(fu_grant), 64'b0100);
        tick();
        squash = 1'b1;
        fu_req = 4'b0001;
        #1;
        chk_cdb("sq.bN1", 1'b1, 3'd5, 32'hDEAD_BEEF);
        check("sq.gN1", 64'(fu_grant), 64'h0);
        tick();
        squash = 1'b0;
        fu_req = 4'b1111;
        #1;
        chk_cdb("sq.bN2", 1'b0, 3'd5, 32'hDEAD_BEEF);
        check("sq.ptr3", 64'(fu_grant), 64'b1000);
        tick();
        // rr_ptr=0; grant FU 0 to move pointer to 1
        fu_req = 4'b0001;
        #1;
        check("pre_idle.g0", 64'(fu_grant), 64'b0001);
        tick();
        fu_req = 4'b0000;
        #1;
        check("idle.g", 64'(fu_grant), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle.valid", 64'(cdb_valid), 64'h0);
            check("idle.g", 64'(fu_grant), 64'h0);
        end
        fu_req = 4'b1111;
        #1;
        check("idle.ptr1", 64'(fu_grant), 64'b0010);
        tick(); #1;
        chk_cdb("idle.b1", 1'b1, 3'd2, 32'd102);
        // Async reset mid-broadcast
        #2;
        reset = 1'b0;
        #1;
        chk_cdb("arst", 1'b0, 3'd0, 32'd0);
        check("arst.g", 64'(fu_grant), 64'h0);
        tick();
        reset  = 1'b1;
        // rr_ptr=0; grant FU 1 so pointer becomes 2
        fu_req = 4'b0010;
        #1;
        check("prio.pre", 64'(fu_grant), 64'b0010);
        tick();
        fu_req = 4'b0101;
        #1;
`ifdef CDB_ARB_BRANCH_PRIO_EN
        check("prio.g0", 64'(fu_grant), 64'b0001);
        tick();
        fu_req = 4'b0100;
        #1;
        chk_cdb("prio.b0", 1'b1, 3'd1, 32'd101);
        check("prio.g2", 64'(fu_grant), 64'b0100);
        tick(); #1;
        chk_cdb("prio.b2", 1'b1, 3'd5, 32'hDEAD_BEEF);
`else
        check("rr.g2", 64'(fu_grant), 64'b0100);
        tick();
        // rr_ptr=3 now, FU 0 reached by wrap
        fu_req = 4'b0101;
        #1;
        chk_cdb("rr.b2", 1'b1, 3'd5, 32'hDEAD_BEEF);
        check("rr.g0", 64'(fu_grant), 64'b0001);
        tick(); #1;
        chk_cdb("rr.b0", 1'b1, 3'd1, 32'd101);
`endif
        fu_req = 4'b0000;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
